// File: rtl/snake_pkg.sv
// Shared constants for the snake key-conditioning stage: heading codes and key indices.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int NUM_KEYS  = 6;
    localparam int KEY_START = 0;
    localparam int KEY_ESC   = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_LEFT  = 4;
    localparam int KEY_RIGHT = 5;

    // Reversing onto your own body is the heading with bit 0 flipped.
    function automatic dir_t opposite(dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: optional polarity fix, 2-flop synchroniser, stability counter,
// debounced level and a registered single-cycle press event.
module key_debounce
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit KEY_ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          key_in;
    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    assign key_in = KEY_ACTIVE_HIGH ? key_raw : ~key_raw;

    // Synchronise, then accept a new level only after it has held for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != stable) begin
                if (cnt == LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                    press  <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/snake_key_cond.sv
// Button conditioning for the snake controller: debounced start/esc pulses and a
// heading register that queues one legal turn and commits it on the game step strobe.
module snake_key_cond
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit KEY_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] key_raw,
    input  logic       tick,
    input  logic       game_run,
    output logic       start_pulse,
    output logic       esc_pulse,
    output logic [1:0] dir,
    output logic       dir_commit,
    output logic       pend_valid
);

    logic [NUM_KEYS-1:0] press;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .KEY_ACTIVE_HIGH (KEY_ACTIVE_HIGH)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .key_raw (key_raw[i]),
            .press   (press[i])
        );
    end

    dir_t dir_q, dir_d;
    dir_t pend_dir_q, pend_dir_d;
    logic pend_q, pend_d;
    logic commit_q, commit_d;
    dir_t req;
    logic req_any;
    dir_t base;

    assign start_pulse = press[KEY_START];
    assign esc_pulse   = press[KEY_ESC];
    assign dir         = dir_q;
    assign dir_commit  = commit_q;
    assign pend_valid  = pend_q;

    // Collapse simultaneous direction presses by priority up > down > left > right.
    always_comb begin
        req     = DIR_RIGHT;
        req_any = |press[KEY_RIGHT:KEY_UP];
        if (press[KEY_UP])        req = DIR_UP;
        else if (press[KEY_DOWN]) req = DIR_DOWN;
        else if (press[KEY_LEFT]) req = DIR_LEFT;
    end

    // Commit the queued turn first so a same-cycle press is judged against the new heading.
    always_comb begin
        dir_d      = dir_q;
        pend_dir_d = pend_dir_q;
        pend_d     = pend_q;
        commit_d   = 1'b0;
        base       = dir_q;
        if (tick && pend_q) begin
            dir_d    = pend_dir_q;
            pend_d   = 1'b0;
            commit_d = 1'b1;
            base     = pend_dir_q;
        end
        if (game_run && req_any && (req != base) && (req != opposite(base))) begin
            pend_dir_d = req;
            pend_d     = 1'b1;
        end
        if (press[KEY_START] && !game_run) begin
            dir_d    = DIR_RIGHT;
            pend_d   = 1'b0;
            commit_d = 1'b0;
        end
    end

    // Heading state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q      <= DIR_RIGHT;
            pend_dir_q <= DIR_RIGHT;
            pend_q     <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            pend_dir_q <= pend_dir_d;
            pend_q     <= pend_d;
            commit_q   <= commit_d;
        end
    end

endmodule

// File: tb/tb_snake_key_cond.sv
// Directed plus random bench for snake_key_cond with a window-based debounce model.
module tb_snake_key_cond;

    localparam int D = 4;
    localparam logic [1:0] H_UP = 2'd0, H_DOWN = 2'd1, H_LEFT = 2'd2, H_RIGHT = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] key_raw;
    logic       tick;
    logic       game_run;
    logic       start_pulse;
    logic       esc_pulse;
    logic [1:0] dir;
    logic       dir_commit;
    logic       pend_valid;

    int n_chk = 0;
    int n_err = 0;

    // Model: hist[k] bit 0 is the raw sample from the previous edge; stable flips once
    // the D samples that have passed through the synchroniser all show the other level.
    logic [D+1:0] hist [6];
    logic [5:0]   m_stable;
    logic [5:0]   m_ev;
    logic [1:0]   m_dir;
    logic [1:0]   m_pd;
    logic         m_pv;
    logic         m_com;

    snake_key_cond #(
        .DEBOUNCE_CYCLES (D),
        .KEY_ACTIVE_HIGH (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .tick        (tick),
        .game_run    (game_run),
        .start_pulse (start_pulse),
        .esc_pulse   (esc_pulse),
        .dir         (dir),
        .dir_commit  (dir_commit),
        .pend_valid  (pend_valid)
    );

    always #5 clk = ~clk;

    function automatic logic turn_ok(logic [1:0] r, logic [1:0] d);
        return (r != d) && (r != (d ^ 2'd1));
    endfunction

    task automatic chk(string tag, logic [1:0] got, logic [1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [5:0]   ev_used;
        logic [5:0]   ev_new;
        logic [D-1:0] win;
        logic [1:0]   r;
        if (rst) begin
            for (int k = 0; k < 6; k++) hist[k] = '0;
            m_stable = '0;
            m_ev     = '0;
            m_dir    = H_RIGHT;
            m_pd     = H_RIGHT;
            m_pv     = 1'b0;
            m_com    = 1'b0;
            return;
        end
        ev_used = m_ev;
        m_com   = 1'b0;
        if (tick && m_pv) begin
            m_dir = m_pd;
            m_pv  = 1'b0;
            m_com = 1'b1;
        end
        if (game_run && (ev_used[5:2] != 4'b0000)) begin
            r = ev_used[2] ? H_UP : ev_used[3] ? H_DOWN : ev_used[4] ? H_LEFT : H_RIGHT;
            if (turn_ok(r, m_dir)) begin
                m_pd = r;
                m_pv = 1'b1;
            end
        end
        if (ev_used[0] && !game_run) begin
            m_dir = H_RIGHT;
            m_pv  = 1'b0;
            m_com = 1'b0;
        end
        for (int k = 0; k < 6; k++) begin
            win       = hist[k][D:1];
            ev_new[k] = 1'b0;
            if (!m_stable[k] && win == '1) begin
                m_stable[k] = 1'b1;
                ev_new[k]   = 1'b1;
            end else if (m_stable[k] && win == '0) begin
                m_stable[k] = 1'b0;
            end
            hist[k] = {hist[k][D:0], key_raw[k]};
        end
        m_ev = ev_new;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("start_pulse", {1'b0, start_pulse}, {1'b0, m_ev[0]});
        chk("esc_pulse",   {1'b0, esc_pulse},   {1'b0, m_ev[1]});
        chk("dir",         dir,                 m_dir);
        chk("dir_commit",  {1'b0, dir_commit},  {1'b0, m_com});
        chk("pend_valid",  {1'b0, pend_valid},  {1'b0, m_pv});
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic press_key(int k);
        key_raw[k] = 1'b1;
        run(D + 3);
        key_raw[k] = 1'b0;
        run(D + 3);
    endtask

    task automatic wait_ev(int k);
        int n = 0;
        while (!m_ev[k] && n < 12) begin
            step();
            n++;
        end
        if (!m_ev[k]) begin
            n_err++;
            $error("FAIL wait_ev: key %0d event not seen within 12 cycles", k);
        end
    endtask

    initial begin
        rst = 1'b1; key_raw = '0; tick = 1'b0; game_run = 1'b1;
        run(3);
        chk("rst_dir", dir, H_RIGHT);
        chk("rst_pv", {1'b0, pend_valid}, 2'd0);
        chk("rst_start", {1'b0, start_pulse}, 2'd0);
        rst = 1'b0;

        // Bounce shorter than the debounce window.
        key_raw[2] = 1'b1; run(3); key_raw[2] = 1'b0; run(8);
        chk("bounce_dir", dir, H_RIGHT);
        chk("bounce_pv", {1'b0, pend_valid}, 2'd0);

        // Held up press, then tick commits it.
        key_raw[2] = 1'b1; run(D + 3);
        chk("up_pend", {1'b0, pend_valid}, 2'd1);
        run(3);
        tick = 1'b1; step(); tick = 1'b0;
        chk("up_dir", dir, H_UP);
        chk("up_commit", {1'b0, dir_commit}, 2'd1);
        chk("up_pv_clr", {1'b0, pend_valid}, 2'd0);
        step();
        chk("up_commit_1cyc", {1'b0, dir_commit}, 2'd0);
        key_raw[2] = 1'b0; run(D + 3);

        // Game stopped: direction ignored, start resets heading.
        game_run = 1'b0;
        press_key(3);
        chk("idle_dir", dir, H_UP);
        chk("idle_pv", {1'b0, pend_valid}, 2'd0);
        key_raw[0] = 1'b1; wait_ev(0);
        chk("start_pulse_hi", {1'b0, start_pulse}, 2'd1);
        step();
        chk("start_pulse_lo", {1'b0, start_pulse}, 2'd0);
        chk("start_dir", dir, H_RIGHT);
        key_raw[0] = 1'b0; run(D + 3);

        // Reject reversal, last accepted press wins.
        game_run = 1'b1;
        press_key(4);
        chk("left_rej", {1'b0, pend_valid}, 2'd0);
        press_key(2);
        chk("up_acc", {1'b0, pend_valid}, 2'd1);
        press_key(3);
        tick = 1'b1; step(); tick = 1'b0;
        chk("last_wins", dir, H_DOWN);

        // Back to RIGHT, then simultaneous up+left.
        game_run = 1'b0; press_key(0); game_run = 1'b1;
        chk("restart_dir", dir, H_RIGHT);
        key_raw[2] = 1'b1; key_raw[4] = 1'b1; run(D + 3);
        key_raw[2] = 1'b0; key_raw[4] = 1'b0; run(D + 3);
        chk("prio_pv", {1'b0, pend_valid}, 2'd1);

        // Tick coincides with a right press: UP commits, RIGHT queued.
        key_raw[5] = 1'b1; wait_ev(5);
        tick = 1'b1; step(); tick = 1'b0;
        chk("same_dir", dir, H_UP);
        chk("same_commit", {1'b0, dir_commit}, 2'd1);
        chk("same_pv", {1'b0, pend_valid}, 2'd1);
        key_raw[5] = 1'b0; run(D + 3);
        tick = 1'b1; step(); tick = 1'b0;
        chk("right_dir", dir, H_RIGHT);

        // Reset mid-debounce with up held.
        key_raw[2] = 1'b1; run(4);
        rst = 1'b1; run(2);
        chk("mid_rst_dir", dir, H_RIGHT);
        chk("mid_rst_pv", {1'b0, pend_valid}, 2'd0);
        rst = 1'b0;
        run(D + 6);
        chk("redebounce_pv", {1'b0, pend_valid}, 2'd1);
        key_raw[2] = 1'b0; run(D + 3);

        // Random keys, ticks, run level and occasional reset.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 6; k++)
                if ($urandom_range(0, 9) == 0) key_raw[k] = ~key_raw[k];
            tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) game_run = ~game_run;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
